// File: rtl/wb_bus_ctrl_if.sv
// wb_bus_ctrl_if
//   Bundles the CPU-side and peripheral-side Wishbone signals of the
//   single-master interconnect.
//   modport slave  : the interconnect's view (CPU request in, slave strobes out)
//   modport master : the environment's view (CPU master plus peripheral models)
//   m_*_i  CPU request (cyc, stb, we, sel, addr, write data)
//   m_*_o  CPU response (read data, ack, err)
//   s_*_o  per-slave cyc/stb and broadcast we/sel/addr/write data
//   s_*_i  packed slave read data and per-slave acks
interface wb_bus_ctrl_if #(
  parameter int NUM_SLAVES = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                             m_cyc_i;
  logic                             m_stb_i;
  logic                             m_we_i;
  logic [DATA_WIDTH/8-1:0]          m_sel_i;
  logic [ADDR_WIDTH-1:0]            m_addr_i;
  logic [DATA_WIDTH-1:0]            m_data_i;
  logic [DATA_WIDTH-1:0]            m_data_o;
  logic                             m_ack_o;
  logic                             m_err_o;
  logic [NUM_SLAVES-1:0]            s_cyc_o;
  logic [NUM_SLAVES-1:0]            s_stb_o;
  logic                             s_we_o;
  logic [DATA_WIDTH/8-1:0]          s_sel_o;
  logic [ADDR_WIDTH-1:0]            s_addr_o;
  logic [DATA_WIDTH-1:0]            s_data_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data_i;
  logic [NUM_SLAVES-1:0]            s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_data_i,
    output m_data_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_data_i,
    input  m_data_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
    output s_data_i, s_ack_i
  );
endinterface

// File: rtl/wb_bus_ctrl.sv
// wb_bus_ctrl
//   Single-master Wishbone interconnect. The slave index is decoded from
//   addr[DEC_MSB:DEC_LSB]; mapped requests strobe exactly one slave with
//   registered cyc/stb, unmapped requests and slaves that never ack within
//   TIMEOUT cycles are answered with a one-cycle error pulse.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : wb_bus_ctrl_if.slave (CPU request/response, per-slave strobes,
//          broadcast we/sel/addr/data, packed slave read data and acks)
//
//   state | meaning
//   IDLE  | waiting for m_cyc_i & m_stb_i, request latched on accept
//   BUSY  | selected slave strobed, waiting for its ack or the timeout
//   DONE  | one-cycle m_ack_o or m_err_o pulse to the master
module wb_bus_ctrl #(
  parameter int NUM_SLAVES = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEC_MSB    = 31,
  parameter int DEC_LSB    = 28,
  parameter int TIMEOUT    = 255
) (
  input  logic           clk,
  input  logic           rst,
  wb_bus_ctrl_if.slave   bus
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = DEC_MSB - DEC_LSB + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic [IDX_W-1:0]      req_idx;
  logic                  req_hit;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  slv_ack;
  logic [DATA_WIDTH-1:0] slv_rdata;

  assign req_idx = bus.m_addr_i[DEC_MSB:DEC_LSB];
  assign req_hit = ({1'b0, req_idx} < (IDX_W + 1)'(NUM_SLAVES));
  // cyc_q is one-hot on the selected slave, so masking filters stray acks
  assign slv_ack = |(bus.s_ack_i & cyc_q);

  always_comb begin
    req_onehot = '0;
    slv_rdata  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot[k] = (req_idx == IDX_W'(k));
      if (idx_q == IDX_W'(k)) begin
        slv_rdata = bus.s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          idx_d   = req_idx;
          we_d    = bus.m_we_i;
          sel_d   = bus.m_sel_i;
          addr_d  = bus.m_addr_i;
          wdata_d = bus.m_data_i;
          cnt_d   = '0;
          if (req_hit) begin
            cyc_d   = req_onehot;
            state_d = ST_BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (!bus.m_cyc_i) begin
          // master abandoned the cycle: no response is owed
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else if (slv_ack) begin
          if (!we_q) begin
            rdata_d = slv_rdata;
          end
          cyc_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_TC) begin
          cyc_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_data_o = rdata_q;
  assign bus.m_ack_o  = ack_q;
  assign bus.m_err_o  = err_q;
  assign bus.s_cyc_o  = cyc_q;
  assign bus.s_stb_o  = cyc_q;
  assign bus.s_we_o   = we_q;
  assign bus.s_sel_o  = sel_q;
  assign bus.s_addr_o = addr_q;
  assign bus.s_data_o = wdata_q;

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// tb_wb_bus_ctrl
//   Bench for wb_bus_ctrl: a master driver, per-slave responder models and
//   a response scoreboard keyed on request cycle.
module tb_wb_bus_ctrl;
  localparam int NS = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  typedef struct {
    logic          is_err;
    logic [DW-1:0] data;
    int            req_cyc;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_bus_ctrl_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_bus_ctrl #(
    .NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DEC_MSB(31), .DEC_LSB(28), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc_cnt = 0;
  int            slv_wait [NS];
  bit            slv_never[NS];
  logic [DW-1:0] slv_data [NS];
  bit            spur0 = 1'b0;
  logic [DW-1:0] last_rd = '0;
  exp_t          sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // slave models: slave k acks after slv_wait[k] strobed cycles; slave 0
  // can additionally be forced to ack on its own via spur0
  int            wcnt[NS];
  logic [NS-1:0] ack_v;
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NS; k++) begin
      if (bus.s_stb_o[k]) begin
        ack_v[k] = !slv_never[k] && (wcnt[k] == slv_wait[k]);
        wcnt[k]++;
      end else begin
        ack_v[k] = 1'b0;
        wcnt[k]  = 0;
      end
    end
    if (spur0) ack_v[0] = 1'b1;
    bus.s_ack_i = ack_v;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.m_ack_o || bus.m_err_o)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {bus.m_ack_o, bus.m_err_o}, 0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_err",  bus.m_err_o, e.is_err);
        chk("resp_ack",  bus.m_ack_o, !e.is_err);
        chk("resp_data", bus.m_data_o, e.data);
        chk("resp_lat",  cyc_cnt - e.req_cyc, e.lat);
      end
    end
  end

  task automatic set_slave(input int k, input int w, input bit nv, input logic [DW-1:0] d);
    slv_wait[k]  = w;
    slv_never[k] = nv;
    slv_data[k]  = d;
    bus.s_data_i[k*DW +: DW] = d;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [3:0] sel,
                       input logic [DW-1:0] wdata, input int slave, input bit exp_err,
                       input int exp_lat, input int exp_n);
    logic [NS-1:0] exp_stb;
    exp_t e;
    int   n;
    bit   done;
    exp_stb = '0;
    if (slave >= 0) exp_stb[slave] = 1'b1;
    if (!we && !exp_err) last_rd = slv_data[slave];
    @(posedge clk); #1;
    bus.m_cyc_i  = 1'b1;
    bus.m_stb_i  = 1'b1;
    bus.m_we_i   = we;
    bus.m_sel_i  = sel;
    bus.m_addr_i = addr;
    bus.m_data_i = wdata;
    e.is_err  = exp_err;
    e.data    = last_rd;
    e.req_cyc = cyc_cnt;
    e.lat     = exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    chk("stb_pre", bus.s_stb_o, 0);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.m_ack_o || bus.m_err_o) begin
        done = 1'b1;
      end else begin
        chk("stb",   bus.s_stb_o,  exp_stb);
        chk("cyc",   bus.s_cyc_o,  exp_stb);
        chk("we",    bus.s_we_o,   we);
        chk("sel",   bus.s_sel_o,  sel);
        chk("addr",  bus.s_addr_o, addr);
        chk("wdata", bus.s_data_o, wdata);
        n++;
      end
    end
    chk("done_seen",  done, 1);
    chk("stb_cycles", n, exp_n);
    @(posedge clk); #1;
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.m_cyc_i  = 1'b0;
    bus.m_stb_i  = 1'b0;
    bus.m_we_i   = 1'b0;
    bus.m_sel_i  = '0;
    bus.m_addr_i = '0;
    bus.m_data_i = '0;
    bus.s_data_i = '0;
    bus.s_ack_i  = '0;
    for (int k = 0; k < NS; k++) set_slave(k, 0, 1'b0, 32'h1000_0000 + k);
    repeat (3) @(negedge clk);
    chk("rst_cyc",  bus.s_cyc_o,  0);
    chk("rst_ack",  bus.m_ack_o,  0);
    chk("rst_err",  bus.m_err_o,  0);
    chk("rst_data", bus.m_data_o, 0);
    chk("rst_addr", bus.s_addr_o, 0);
    chk("rst_we",   bus.s_we_o,   0);
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait read from slave 2
    set_slave(2, 0, 1'b0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h2000_0010, 4'hF, 32'h0, 2, 1'b0, 2, 1);

    // write to slave 5 with three wait states: ack coincides with terminal count
    set_slave(5, 3, 1'b0, 32'h5555_5555);
    issue(1'b1, 32'h5000_0004, 4'b0011, 32'h0000_1234, 5, 1'b0, 5, 4);

    // unmapped index 9
    issue(1'b0, 32'h9000_0000, 4'hF, 32'h0, -1, 1'b1, 1, 0);

    // slave 1 silent, slave 0 acking spuriously throughout
    set_slave(1, 0, 1'b1, 32'h1111_1111);
    spur0 = 1'b1;
    issue(1'b0, 32'h1000_0020, 4'hF, 32'h0, 1, 1'b1, 1 + TO, TO);
    spur0 = 1'b0;

    // master abort while slave 3 is strobed
    set_slave(3, 0, 1'b1, 32'h3333_3333);
    @(posedge clk); #1;
    bus.m_cyc_i  = 1'b1;
    bus.m_stb_i  = 1'b1;
    bus.m_we_i   = 1'b0;
    bus.m_addr_i = 32'h3000_0000;
    @(negedge clk);
    @(negedge clk);
    chk("abort_stb_on", bus.s_stb_o, 8'h08);
    @(posedge clk); #1;
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_stb_off", bus.s_stb_o, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", {bus.m_ack_o, bus.m_err_o}, 0);
    end

    // normal read after abort, two wait states
    set_slave(2, 2, 1'b0, 32'h0BAD_F00D);
    issue(1'b0, 32'h2000_0000, 4'hF, 32'h0, 2, 1'b0, 4, 3);

    // asynchronous reset in the middle of a slave 3 cycle
    @(posedge clk); #1;
    bus.m_cyc_i  = 1'b1;
    bus.m_stb_i  = 1'b1;
    bus.m_we_i   = 1'b0;
    bus.m_addr_i = 32'h3000_0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_stb", bus.s_stb_o, 8'h08);
    rst = 1'b1;
    #1;
    chk("rst_busy_cyc",  bus.s_cyc_o,  0);
    chk("rst_busy_resp", {bus.m_ack_o, bus.m_err_o}, 0);
    chk("rst_busy_data", bus.m_data_o, 0);
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    last_rd     = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", bus.s_cyc_o, 0);
    end

    // one-wait read from slave 7 after reset
    set_slave(7, 1, 1'b0, 32'hCAFE_F00D);
    issue(1'b0, 32'h7000_0008, 4'hF, 32'h0, 7, 1'b0, 3, 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
